// File: rtl/tdc_readout_ctrl.sv
// ----------------------------------------------------------------------------
// tdc_readout_ctrl
// Purpose : Sequences a TDC through arm/acquire/capture/drain phases, filters
//           captured hits on their Cal code, buffers accepted 30-bit records
//           in a small FIFO and presents them on a valid/ready output port.
//
// Ports   : clk40                  - sole clock, rising edge
//           reset                  - asynchronous, active-high reset
//           run                    - 1 = acquire, 0 = drain then idle
//           hitFlag                - TDC conversion-done strobe (1 cycle)
//           TOA_code/TOT_code/Cal_code, *errorFlag
//                                  - TDC codes and flags, valid the cycle after hitFlag
//           tdcEnable, tdcTestMode - TDC control outputs
//           dataOut/dataValid/dataReady
//                                  - record {errAny, Cal, TOT, TOA} with handshake
//           dropCnt                - saturating count of rejected/overflowed records
//           busy                   - controller is not idle
//
// Options : TDC_CTRL_SELFTEST_EN   - when defined, pulses tdcTestMode once
//                                    every 256 cycles of acquisition
// ----------------------------------------------------------------------------
module tdc_readout_ctrl #(
    parameter int unsigned FIFO_DEPTH = 4,
    parameter logic [9:0]  CAL_LOW    = 10'd100,
    parameter logic [9:0]  CAL_HIGH   = 10'd300
) (
    input  logic        clk40,
    input  logic        reset,
    input  logic        run,
    input  logic        hitFlag,
    input  logic [9:0]  TOA_code,
    input  logic [8:0]  TOT_code,
    input  logic [9:0]  Cal_code,
    input  logic        TOAerrorFlag,
    input  logic        TOTerrorFlag,
    input  logic        CalerrorFlag,
    output logic        tdcEnable,
    output logic        tdcTestMode,
    output logic [29:0] dataOut,
    output logic        dataValid,
    input  logic        dataReady,
    output logic [7:0]  dropCnt,
    output logic        busy
);

    localparam int unsigned REC_W = 30;
    localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
    localparam int unsigned CNT_W = $clog2(FIFO_DEPTH + 1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_ARM   = 3'd1,
        S_ACQ   = 3'd2,
        S_CAPT  = 3'd3,
        S_DRAIN = 3'd4
    } state_t;

    state_t             r_state;
    state_t             w_state_next;
    logic               r_rst_hold;
    logic               r_arm_cnt;

    logic [REC_W-1:0]   r_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]   r_wr_ptr;
    logic [PTR_W-1:0]   r_rd_ptr;
    logic [CNT_W-1:0]   r_count;
    logic [REC_W-1:0]   r_data_out;
    logic               r_valid;
    logic [7:0]         r_drop_cnt;
    logic               r_enable;
    logic               r_busy;

    logic               w_err_any;
    logic               w_cal_ok;
    logic               w_capt;
    logic               w_pop;
    logic               w_full;
    logic               w_push;
    logic               w_drop;
    logic [REC_W-1:0]   w_record;
    logic [PTR_W-1:0]   w_wr_ptr_next;
    logic [PTR_W-1:0]   w_rd_ptr_next;
    logic [CNT_W-1:0]   w_count_next;
    logic [REC_W-1:0]   w_head_next;

    // Pointer advance, wrapping modulo FIFO_DEPTH
    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(FIFO_DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    // Holds the FSM for one edge after reset release so the first state
    // change lands on the second edge.
    always_ff @(posedge clk40 or posedge reset) begin
        if (reset) begin
            r_rst_hold <= 1'b1;
        end else begin
            r_rst_hold <= 1'b0;
        end
    end

    // State register
    always_ff @(posedge clk40 or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state logic
    always_comb begin
        w_state_next = r_state;
        if (!r_rst_hold) begin
            case (r_state)
                S_IDLE:  if (run) w_state_next = S_ARM;
                S_ARM:   if (r_arm_cnt) w_state_next = S_ACQ;
                // A hit wins over run=0; the capture then completes into DRAIN
                S_ACQ: begin
                    if (hitFlag) begin
                        w_state_next = S_CAPT;
                    end else if (!run) begin
                        w_state_next = S_DRAIN;
                    end
                end
                S_CAPT:  w_state_next = run ? S_ACQ : S_DRAIN;
                S_DRAIN: if (r_count == '0) w_state_next = S_IDLE;
                default: w_state_next = S_IDLE;
            endcase
        end
    end

    // ARM lasts exactly two cycles
    always_ff @(posedge clk40 or posedge reset) begin
        if (reset) begin
            r_arm_cnt <= 1'b0;
        end else begin
            r_arm_cnt <= (r_state == S_ARM) ? ~r_arm_cnt : 1'b0;
        end
    end

    // Capture filter and FIFO control
    always_comb begin
        w_err_any     = TOAerrorFlag | TOTerrorFlag | CalerrorFlag;
        w_cal_ok      = (Cal_code >= CAL_LOW) && (Cal_code <= CAL_HIGH);
        w_capt        = (r_state == S_CAPT);
        w_record      = {w_err_any, Cal_code, TOT_code, TOA_code};
        w_pop         = r_valid && dataReady;
        w_full        = (r_count == CNT_W'(FIFO_DEPTH));
        // A simultaneous pop frees the slot, so a full FIFO still accepts
        w_push        = w_capt && w_cal_ok && (!w_full || w_pop);
        w_drop        = w_capt && (!w_cal_ok || (w_full && !w_pop));
        w_wr_ptr_next = w_push ? ptr_inc(r_wr_ptr) : r_wr_ptr;
        w_rd_ptr_next = w_pop  ? ptr_inc(r_rd_ptr) : r_rd_ptr;
        w_count_next  = r_count + CNT_W'(w_push) - CNT_W'(w_pop);
        // Next head is the incoming record when it lands in the head slot
        if (w_push && (r_wr_ptr == w_rd_ptr_next)) begin
            w_head_next = w_record;
        end else begin
            w_head_next = r_mem[w_rd_ptr_next];
        end
    end

    // Record storage
    always_ff @(posedge clk40) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= w_record;
        end
    end

    // FIFO pointers, occupancy and registered output stage
    always_ff @(posedge clk40 or posedge reset) begin
        if (reset) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_valid    <= 1'b0;
            r_data_out <= '0;
        end else begin
            r_wr_ptr   <= w_wr_ptr_next;
            r_rd_ptr   <= w_rd_ptr_next;
            r_count    <= w_count_next;
            r_valid    <= (w_count_next != '0);
            r_data_out <= (w_count_next != '0) ? w_head_next : '0;
        end
    end

    // Saturating drop counter
    always_ff @(posedge clk40 or posedge reset) begin
        if (reset) begin
            r_drop_cnt <= '0;
        end else if (w_drop && (r_drop_cnt != 8'hFF)) begin
            r_drop_cnt <= r_drop_cnt + 8'd1;
        end
    end

    // Control outputs registered from the next state
    always_ff @(posedge clk40 or posedge reset) begin
        if (reset) begin
            r_enable <= 1'b0;
            r_busy   <= 1'b0;
        end else begin
            r_enable <= (w_state_next == S_ARM) || (w_state_next == S_ACQ) ||
                        (w_state_next == S_CAPT);
            r_busy   <= (w_state_next != S_IDLE);
        end
    end

`ifdef TDC_CTRL_SELFTEST_EN
    logic [7:0] r_test_cnt;
    logic [7:0] w_test_cnt_next;
    logic       r_test_mode;

    // Free-running acquisition counter; zeroed while arming so it reads 0
    // in the first ACQ cycle and keeps counting through captures.
    always_comb begin
        w_test_cnt_next = (r_state == S_ARM) ? 8'd0 : r_test_cnt + 8'd1;
    end

    always_ff @(posedge clk40 or posedge reset) begin
        if (reset) begin
            r_test_cnt  <= '0;
            r_test_mode <= 1'b0;
        end else begin
            r_test_cnt  <= w_test_cnt_next;
            r_test_mode <= (w_state_next == S_ACQ) && (w_test_cnt_next == 8'hFF);
        end
    end

    assign tdcTestMode = r_test_mode;
`else
    assign tdcTestMode = 1'b0;
`endif

    assign tdcEnable = r_enable;
    assign busy      = r_busy;
    assign dataOut   = r_data_out;
    assign dataValid = r_valid;
    assign dropCnt   = r_drop_cnt;

endmodule

// File: tb/tb_tdc_readout_ctrl.sv
// ----------------------------------------------------------------------------
// tb_tdc_readout_ctrl
// Directed bench for tdc_readout_ctrl. A queue-based model of the controller
// is stepped every clock and compared against the DUT outputs; directed
// sequences add hand-computed literal expectations.
// ----------------------------------------------------------------------------
module tb_tdc_readout_ctrl;

    localparam int unsigned DEPTH    = 4;
    localparam logic [9:0]  CAL_LOW  = 10'd100;
    localparam logic [9:0]  CAL_HIGH = 10'd300;

    logic        clk40 = 1'b0;
    logic        reset;
    logic        run = 1'b0;
    logic        hitFlag = 1'b0;
    logic [9:0]  TOA_code = '0;
    logic [8:0]  TOT_code = '0;
    logic [9:0]  Cal_code = '0;
    logic        TOAerrorFlag = 1'b0;
    logic        TOTerrorFlag = 1'b0;
    logic        CalerrorFlag = 1'b0;
    logic        tdcEnable;
    logic        tdcTestMode;
    logic [29:0] dataOut;
    logic        dataValid;
    logic        dataReady = 1'b0;
    logic [7:0]  dropCnt;
    logic        busy;

    tdc_readout_ctrl #(
        .FIFO_DEPTH (DEPTH),
        .CAL_LOW    (CAL_LOW),
        .CAL_HIGH   (CAL_HIGH)
    ) dut (
        .clk40        (clk40),
        .reset        (reset),
        .run          (run),
        .hitFlag      (hitFlag),
        .TOA_code     (TOA_code),
        .TOT_code     (TOT_code),
        .Cal_code     (Cal_code),
        .TOAerrorFlag (TOAerrorFlag),
        .TOTerrorFlag (TOTerrorFlag),
        .CalerrorFlag (CalerrorFlag),
        .tdcEnable    (tdcEnable),
        .tdcTestMode  (tdcTestMode),
        .dataOut      (dataOut),
        .dataValid    (dataValid),
        .dataReady    (dataReady),
        .dropCnt      (dropCnt),
        .busy         (busy)
    );

    always #5 clk40 = ~clk40;

    int n_chk = 0;
    int n_err = 0;
    bit done  = 1'b0;

    // ---------------- behavioural model ----------------
    typedef enum {M_IDLE, M_ARM, M_ACQ, M_CAPT, M_DRAIN} mph_t;
    mph_t        m_ph   = M_IDLE;
    int          m_arm  = 0;
    bit          m_hold = 1'b1;
    int          m_drop = 0;
    logic [7:0]  m_tc   = '0;
    logic [29:0] q[$];

    task automatic m_reset();
        m_ph   = M_IDLE;
        m_arm  = 0;
        m_hold = 1'b1;
        m_drop = 0;
        m_tc   = '0;
        q.delete();
    endtask

    task automatic m_step();
        int          n    = q.size();
        bit          pop  = (n > 0) && dataReady;
        bit          capt = (m_ph == M_CAPT);
        logic [29:0] rec  = {TOAerrorFlag | TOTerrorFlag | CalerrorFlag,
                             Cal_code, TOT_code, TOA_code};
        m_tc = (m_ph == M_ARM) ? 8'd0 : m_tc + 8'd1;
        if (m_hold) begin
            m_hold = 1'b0;
            return;
        end
        case (m_ph)
            M_IDLE:  if (run) begin m_ph = M_ARM; m_arm = 2; end
            M_ARM:   begin m_arm--; if (m_arm == 0) m_ph = M_ACQ; end
            M_ACQ:   if (hitFlag) m_ph = M_CAPT; else if (!run) m_ph = M_DRAIN;
            M_CAPT:  m_ph = run ? M_ACQ : M_DRAIN;
            M_DRAIN: if (n == 0) m_ph = M_IDLE;
            default: m_ph = M_IDLE;
        endcase
        if (pop) void'(q.pop_front());
        if (capt) begin
            if (Cal_code < CAL_LOW || Cal_code > CAL_HIGH || (n == int'(DEPTH) && !pop)) begin
                if (m_drop < 255) m_drop++;
            end else begin
                q.push_back(rec);
            end
        end
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    task automatic m_compare();
        bit exp_test;
`ifdef TDC_CTRL_SELFTEST_EN
        exp_test = (m_ph == M_ACQ) && (m_tc == 8'hFF);
`else
        exp_test = 1'b0;
`endif
        chk("model_dataValid", 32'(dataValid), 32'(q.size() > 0));
        if (q.size() > 0) chk("model_dataOut", 32'(dataOut), 32'(q[0]));
        if (reset) chk("model_dataOut_rst", 32'(dataOut), 32'd0);
        chk("model_dropCnt", 32'(dropCnt), 32'(m_drop));
        chk("model_busy", 32'(busy), 32'(m_ph != M_IDLE));
        chk("model_tdcEnable", 32'(tdcEnable),
            32'(m_ph == M_ARM || m_ph == M_ACQ || m_ph == M_CAPT));
        chk("model_tdcTestMode", 32'(tdcTestMode), 32'(exp_test));
    endtask

    // ---------------- stimulus helpers ----------------
    // Called at a negedge while in ACQ; returns at the negedge two cycles later.
    task automatic hit(input logic [9:0] a, input logic [8:0] t, input logic [9:0] c,
                       input logic ea);
        hitFlag      = 1'b1;
        TOA_code     = a;
        TOT_code     = t;
        Cal_code     = c;
        TOAerrorFlag = ea;
        @(negedge clk40);
        hitFlag = 1'b0;
        @(negedge clk40);
        TOAerrorFlag = 1'b0;
    endtask

    // Reset, release with run=1, and return at the first ACQ negedge.
    task automatic bring_up();
        @(negedge clk40);
        reset = 1'b1; run = 1'b0; dataReady = 1'b0; hitFlag = 1'b0;
        @(negedge clk40);
        reset = 1'b0; run = 1'b1;
        @(negedge clk40);
        chk("release_hold_busy", 32'(busy), 32'd0);
        @(negedge clk40);
        chk("arm_busy", 32'(busy), 32'd1);
        chk("arm_enable", 32'(tdcEnable), 32'd1);
        // hit in ARM with a reject-range Cal must be ignored
        hitFlag = 1'b1; Cal_code = 10'd5;
        @(negedge clk40);
        hitFlag = 1'b0;
        @(negedge clk40);
        chk("arm_hit_ignored", 32'(dropCnt), 32'd0);
    endtask

    logic [29:0] exp_rec;
    int          pulses;
    int          k;

    initial begin
        reset = 1'b1;
        fork
            begin : monitor
                while (!done) begin
                    @(posedge clk40 or posedge reset);
                    if (reset) m_reset();
                    else       m_step();
                    #1;
                    m_compare();
                end
            end
            begin : stimulus
                @(negedge clk40);
                chk("reset_valid", 32'(dataValid), 32'd0);
                chk("reset_dataOut", 32'(dataOut), 32'd0);
                chk("reset_busy", 32'(busy), 32'd0);

                // single accepted hit: dataValid two cycles after hitFlag
                bring_up();
                dataReady = 1'b1;
                hitFlag = 1'b1; TOA_code = 10'h155; TOT_code = 9'h0AA; Cal_code = 10'd200;
                @(negedge clk40);
                hitFlag = 1'b0;
                chk("lat1_valid", 32'(dataValid), 32'd0);
                @(negedge clk40);
                exp_rec = {1'b0, 10'd200, 9'h0AA, 10'h155};
                chk("lat2_valid", 32'(dataValid), 32'd1);
                chk("lat2_data", 32'(dataOut), 32'(exp_rec));
                @(negedge clk40);
                dataReady = 1'b0;

                // overflow: 6 hits into a 4-deep FIFO
                for (int i = 1; i <= 6; i++) hit(10'(i), 9'(i), 10'd200, 1'b0);
                chk("ovf_drop", 32'(dropCnt), 32'd2);
                dataReady = 1'b1;
                chk("ovf_head", 32'(dataOut[9:0]), 32'd1);
                for (int i = 2; i <= 4; i++) begin
                    @(negedge clk40);
                    chk("ovf_order", 32'(dataOut[9:0]), 32'(i));
                end
                @(negedge clk40);
                chk("ovf_empty", 32'(dataValid), 32'd0);

                // Cal window filtering; error flag alone does not reject
                bring_up();
                dataReady = 1'b1;
                hit(10'd7, 9'd7, 10'd99, 1'b0);
                hit(10'd8, 9'd8, 10'd301, 1'b0);
                hit(10'd9, 9'd9, 10'd100, 1'b1);
                exp_rec = {1'b1, 10'd100, 9'd9, 10'd9};
                chk("filt_valid", 32'(dataValid), 32'd1);
                chk("filt_data", 32'(dataOut), 32'(exp_rec));
                chk("filt_drop", 32'(dropCnt), 32'd2);

                // push+pop on a full FIFO, then drain to idle
                bring_up();
                for (int i = 1; i <= 4; i++) hit(10'(i), 9'd0, 10'd150, 1'b0);
                hitFlag = 1'b1; TOA_code = 10'd5;
                @(negedge clk40);
                hitFlag = 1'b0; dataReady = 1'b1;
                @(negedge clk40);
                dataReady = 1'b0;
                chk("full_pp_drop", 32'(dropCnt), 32'd0);
                chk("full_pp_head", 32'(dataOut[9:0]), 32'd2);
                run = 1'b0; dataReady = 1'b1;
                for (int i = 3; i <= 5; i++) begin
                    @(negedge clk40);
                    chk("drain_order", 32'(dataOut[9:0]), 32'(i));
                end
                k = 0;
                while (busy && k < 8) begin
                    @(negedge clk40);
                    k++;
                end
                chk("drain_idle_busy", 32'(busy), 32'd0);
                chk("drain_idle_enable", 32'(tdcEnable), 32'd0);
                hitFlag = 1'b1; Cal_code = 10'd5;
                @(negedge clk40);
                hitFlag = 1'b0;
                @(negedge clk40);
                chk("idle_hit_ignored", 32'(dropCnt), 32'd0);

                // asynchronous reset during CAPT with records queued
                bring_up();
                hit(10'd1, 9'd0, 10'd50, 1'b0);
                for (int i = 1; i <= 3; i++) hit(10'(i), 9'd0, 10'd200, 1'b0);
                hitFlag = 1'b1; Cal_code = 10'd200;
                @(negedge clk40);
                hitFlag = 1'b0;
                chk("pre_rst_valid", 32'(dataValid), 32'd1);
                chk("pre_rst_drop", 32'(dropCnt), 32'd1);
                reset = 1'b1;
                #1;
                chk("async_rst_valid", 32'(dataValid), 32'd0);
                chk("async_rst_drop", 32'(dropCnt), 32'd0);
                chk("async_rst_enable", 32'(tdcEnable), 32'd0);
                chk("async_rst_busy", 32'(busy), 32'd0);
                #1;
                reset = 1'b0;

                // dropCnt saturation
                bring_up();
                dataReady = 1'b1;
                for (int i = 0; i < 257; i++) hit(10'd0, 9'd0, (i % 2 == 0) ? 10'd0 : 10'd1023, 1'b0);
                chk("drop_saturate", 32'(dropCnt), 32'd255);

                // self-test pulses over 600 acquisition cycles
                bring_up();
                pulses = 0;
                for (int i = 0; i < 600; i++) begin
                    if (tdcTestMode) pulses++;
                    @(negedge clk40);
                end
`ifdef TDC_CTRL_SELFTEST_EN
                chk("selftest_pulses", 32'(pulses), 32'd2);
`else
                chk("selftest_pulses", 32'(pulses), 32'd0);
`endif
                done = 1'b1;
            end
        join
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

endmodule
